// File: rtl/can_frame_tail_checker.sv
// CAN frame tail checker: validates CRC delimiter, ACK slot/delimiter, EOF and intermission
// bit by bit on the sample point, flagging form/ACK errors, overload and early SOF.
module can_frame_tail_checker #(
  parameter int unsigned EOF_LEN   = 7,
  parameter int unsigned IFS_LEN   = 3,
  parameter int unsigned CHECK_ACK = 0,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       Tail_Start,
  output logic       Error_n,
  output logic [2:0] Error_Code,
  output logic       Overload,
  output logic       SOF_Detect,
  output logic       Done,
  output logic       Busy
);

  localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_LEN - 1);
  localparam logic [CNT_W-1:0] IFS_LAST = CNT_W'(IFS_LEN - 1);

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_CRC_DEL = 3'd1;
  localparam logic [2:0] CODE_ACK     = 3'd2;
  localparam logic [2:0] CODE_ACK_DEL = 3'd3;
  localparam logic [2:0] CODE_EOF     = 3'd4;

  typedef enum logic [2:0] {StIdle, StCrcDel, StAckSlot, StAckDel, StEof, StIfs} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_error_n;
  logic [2:0]       r_error_code;
  logic             r_overload;
  logic             r_sof;
  logic             r_done;
  logic             r_busy;

  always_ff @(posedge SP) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_error_n    <= 1'b1;
      r_error_code <= CODE_NONE;
      r_overload   <= 1'b0;
      r_sof        <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_overload <= 1'b0;
      r_sof      <= 1'b0;
      r_done     <= 1'b0;
      // A new tail always restarts cleanly, aborting any tail in progress.
      if (Tail_Start) begin
        r_state      <= StCrcDel;
        r_cnt        <= '0;
        r_error_n    <= 1'b1;
        r_error_code <= CODE_NONE;
        r_busy       <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: r_busy <= 1'b0;
          StCrcDel: begin
            if (!RX) begin
              r_error_n    <= 1'b0;
              r_error_code <= CODE_CRC_DEL;
              r_state      <= StIdle;
              r_busy       <= 1'b0;
            end else begin
              r_state <= StAckSlot;
              r_busy  <= 1'b1;
            end
          end
          StAckSlot: begin
            if ((CHECK_ACK != 0) && RX) begin
              r_error_n    <= 1'b0;
              r_error_code <= CODE_ACK;
              r_state      <= StIdle;
              r_busy       <= 1'b0;
            end else begin
              r_state <= StAckDel;
              r_busy  <= 1'b1;
            end
          end
          StAckDel: begin
            if (!RX) begin
              r_error_n    <= 1'b0;
              r_error_code <= CODE_ACK_DEL;
              r_state      <= StIdle;
              r_busy       <= 1'b0;
            end else begin
              r_state <= StEof;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
          StEof: begin
            if (r_cnt == EOF_LAST) begin
              if (RX) begin
                r_state <= StIfs;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
              end else begin
                // Dominant on the last EOF bit is an overload condition, not an error.
                r_overload <= 1'b1;
                r_state    <= StIdle;
                r_busy     <= 1'b0;
              end
            end else if (!RX) begin
              r_error_n    <= 1'b0;
              r_error_code <= CODE_EOF;
              r_state      <= StIdle;
              r_busy       <= 1'b0;
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_busy <= 1'b1;
            end
          end
          StIfs: begin
            if (r_cnt == IFS_LAST) begin
              r_sof   <= ~RX;
              r_done  <= 1'b1;
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else if (!RX) begin
              r_overload <= 1'b1;
              r_state    <= StIdle;
              r_busy     <= 1'b0;
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_busy <= 1'b1;
            end
          end
          default: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Error_n    = r_error_n;
  assign Error_Code = r_error_code;
  assign Overload   = r_overload;
  assign SOF_Detect = r_sof;
  assign Done       = r_done;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_can_frame_tail_checker.sv
// Directed bench for can_frame_tail_checker: one instance without and one with ACK checking,
// driven by the same bus bits.
module tb_can_frame_tail_checker;

  logic       SP = 1'b0;
  logic       reset;
  logic       RX;
  logic       Tail_Start;
  logic       err_n0, ovl0, sof0, done0, busy0;
  logic [2:0] code0;
  logic       err_n1, ovl1, sof1, done1, busy1;
  logic [2:0] code1;

  int n_cmp = 0;
  int n_err = 0;

  can_frame_tail_checker #(.EOF_LEN(7), .IFS_LEN(3), .CHECK_ACK(0), .CNT_W(4)) u_dut0 (
    .SP(SP), .reset(reset), .RX(RX), .Tail_Start(Tail_Start),
    .Error_n(err_n0), .Error_Code(code0), .Overload(ovl0), .SOF_Detect(sof0),
    .Done(done0), .Busy(busy0)
  );

  can_frame_tail_checker #(.EOF_LEN(7), .IFS_LEN(3), .CHECK_ACK(1), .CNT_W(4)) u_dut1 (
    .SP(SP), .reset(reset), .RX(RX), .Tail_Start(Tail_Start),
    .Error_n(err_n1), .Error_Code(code1), .Overload(ovl1), .SOF_Detect(sof1),
    .Done(done1), .Busy(busy1)
  );

  always #5 SP = ~SP;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one sampled bit, then look at the outputs just after the edge that sampled it.
  task automatic step(input logic ts, input logic rx);
    Tail_Start = ts;
    RX         = rx;
    @(posedge SP);
    #1;
  endtask

  task automatic ones(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  int cnt_done, cnt_busy, cnt_ovl, cnt_bad;

  initial begin
    reset = 1'b1; RX = 1'b1; Tail_Start = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_eq("rst_err_n", err_n0, 1);
    check_eq("rst_code", code0, 0);
    check_eq("rst_ovl", ovl0, 0);
    check_eq("rst_sof", sof0, 0);
    check_eq("rst_done", done0, 0);
    check_eq("rst_busy", busy0, 0);
    reset = 1'b0;
    ones(2);

    // Nominal tail: Done 13 edges after Tail_Start; ACK-checking instance flags the ACK slot.
    step(1'b1, 1'b1);
    cnt_done = 0; cnt_busy = busy0 ? 1 : 0; cnt_ovl = 0;
    for (int i = 1; i <= 13; i++) begin
      step(1'b0, 1'b1);
      if (done0) cnt_done++;
      if (ovl0) cnt_ovl++;
      if (busy0) cnt_busy++;
      if (i == 13) check_eq("nom_done_at_13", done0, 1);
    end
    check_eq("nom_done_count", cnt_done, 1);
    check_eq("nom_busy_cycles", cnt_busy, 13);
    check_eq("nom_ovl_count", cnt_ovl, 0);
    check_eq("nom_err_n", err_n0, 1);
    check_eq("nom_busy_end", busy0, 0);
    check_eq("ack_on_code", code1, 2);
    check_eq("ack_on_err_n", err_n1, 0);
    check_eq("ack_on_done", done1, 0);

    // CRC delimiter error, held through idle, cleared by the next Tail_Start.
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_eq("crc_err_n", err_n0, 0);
    check_eq("crc_code", code0, 1);
    check_eq("crc_busy", busy0, 0);
    cnt_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      if (err_n0 !== 1'b0 || code0 !== 3'd1 || busy0 !== 1'b0) cnt_bad++;
    end
    check_eq("crc_hold", cnt_bad, 0);
    step(1'b1, 1'b1);
    check_eq("clr_err_n", err_n0, 1);
    check_eq("clr_code", code0, 0);
    check_eq("clr_busy", busy0, 1);

    // EOF bit 3 dominant.
    ones(3 + 3);
    step(1'b0, 1'b0);
    check_eq("eof_code", code0, 4);
    check_eq("eof_err_n", err_n0, 0);
    cnt_done = done0 ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      if (done0) cnt_done++;
    end
    check_eq("eof_no_done", cnt_done, 0);

    // Dominant on the last EOF bit: overload only.
    step(1'b1, 1'b1);
    ones(3 + 6);
    step(1'b0, 1'b0);
    check_eq("ovl_eof_pulse", ovl0, 1);
    check_eq("ovl_eof_err_n", err_n0, 1);
    check_eq("ovl_eof_code", code0, 0);
    check_eq("ovl_eof_busy", busy0, 0);
    step(1'b0, 1'b1);
    check_eq("ovl_eof_one_cycle", ovl0, 0);

    // Dominant on intermission bit 1: overload, no Done.
    step(1'b1, 1'b1);
    ones(3 + 7 + 1);
    step(1'b0, 1'b0);
    check_eq("ovl_ifs_pulse", ovl0, 1);
    cnt_done = done0 ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      if (done0) cnt_done++;
    end
    check_eq("ovl_ifs_no_done", cnt_done, 0);

    // Reset while the EOF counter is at 4.
    step(1'b1, 1'b1);
    ones(3 + 4);
    check_eq("pre_rst_busy", busy0, 1);
    reset = 1'b1;
    step(1'b0, 1'b0);
    check_eq("mid_rst_busy", busy0, 0);
    check_eq("mid_rst_err_n", err_n0, 1);
    check_eq("mid_rst_code", code0, 0);
    check_eq("mid_rst_ovl", ovl0, 0);
    check_eq("mid_rst_done", done0, 0);
    reset = 1'b0;
    ones(3);

    // Restart at intermission bit 1, then dominant third intermission bit of the new tail.
    step(1'b1, 1'b1);
    ones(3 + 7 + 1);
    step(1'b1, 1'b1);
    check_eq("restart_busy", busy0, 1);
    check_eq("restart_done", done0, 0);
    cnt_done = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1);
      if (done0) cnt_done++;
    end
    check_eq("restart_no_early_done", cnt_done, 0);
    step(1'b0, 1'b0);
    check_eq("sof_pulse", sof0, 1);
    check_eq("sof_done", done0, 1);
    check_eq("sof_ovl", ovl0, 0);
    check_eq("sof_err_n", err_n0, 1);
    step(1'b0, 1'b1);
    check_eq("sof_one_cycle", sof0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
